mezclador_bandas: RTL and testbench

- Recombines the three equalizer band outputs (bajos, medios, altos) from the band-split filter bank into one output sample.
- Applies a signed per-band gain to each band, sums the three results, and saturates the sum to the sample width.
- Sits directly downstream of the band-split filters, on the same clock and the same per-sample `en` strobe.
- Uses one time-multiplexed multiplier, sequenced by a small FSM: one multiply per clock.

---
 rtl/mezclador_bandas_pkg.sv | 25 ++
 rtl/mezclador_bandas_saturador_q.sv | 25 ++
 rtl/mezclador_bandas.sv | 117 +++++++++++
 tb/tb_mezclador_bandas.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mezclador_bandas_pkg.sv
// Shared definitions for the band mixer: Q8.16 format defaults, saturation
// limits, FSM state encoding and the accumulator width rule.
package mezclador_bandas_pkg;

  localparam int SIGNO_DEF    = 1;
  localparam int MAGNITUD_DEF = 8;
  localparam int FRACCION_DEF = 16;
  localparam int ANCHO_DEF    = SIGNO_DEF + MAGNITUD_DEF + FRACCION_DEF;

  localparam logic [ANCHO_DEF-1:0] UNO   = 25'h0010000;
  localparam logic [ANCHO_DEF-1:0] MAX_Q = 25'h0FFFFFF;
  localparam logic [ANCHO_DEF-1:0] MIN_Q = 25'h1000000;

  localparam logic [2:0] REPOSO = 3'd0;
  localparam logic [2:0] MUL_B  = 3'd1;
  localparam logic [2:0] MUL_M  = 3'd2;
  localparam logic [2:0] MUL_A  = 3'd3;
  localparam logic [2:0] SATURA = 3'd4;

  // Three shifted products plus two guard bits, so the sum never wraps.
  function automatic int ancho_acum(input int ancho, input int fraccion);
    return 2 * ancho - fraccion + 2;
  endfunction

endpackage

// File: rtl/mezclador_bandas_saturador_q.sv
// saturador_q: clips a wide signed accumulator to an ancho-bit signed sample
// and flags when clipping happened. Purely combinational.
module saturador_q #(
  parameter int ancho      = 25,
  parameter int ancho_acum = 36
) (
  input  logic [ancho_acum-1:0] dato,
  output logic [ancho-1:0]      sat,
  output logic                  recorte
);

  logic [ancho_acum-ancho:0] alto;

  // The value fits only when every bit from the result sign bit upward agrees.
  always_comb begin
    alto    = dato[ancho_acum-1:ancho-1];
    recorte = !((&alto) || !(|alto));
    sat     = dato[ancho-1:0];
    if (recorte) begin
      if (dato[ancho_acum-1]) sat = {1'b1, {(ancho-1){1'b0}}};
      else                    sat = {1'b0, {(ancho-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mezclador_bandas.sv
// mezclador_bandas: gains and sums the three equalizer bands with one shared
// multiplier, then saturates. Define MEZCLADOR_REDONDEO_EN for round-half-up.
module mezclador_bandas
  import mezclador_bandas_pkg::*;
#(
  parameter int signo    = SIGNO_DEF,
  parameter int magnitud = MAGNITUD_DEF,
  parameter int fraccion = FRACCION_DEF,
  parameter int ancho    = signo + magnitud + fraccion
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [ancho-1:0] ykbajos,
  input  logic [ancho-1:0] ykmedios,
  input  logic [ancho-1:0] ykaltos,
  input  logic [ancho-1:0] ganancia_b,
  input  logic [ancho-1:0] ganancia_m,
  input  logic [ancho-1:0] ganancia_a,
  output logic [ancho-1:0] func_salida,
  output logic             listo,
  output logic             saturado,
  output logic             perdido
);

  localparam int AW = ancho_acum(ancho, fraccion);
  localparam int PW = 2 * ancho;

  // Handshake: en is a one-cycle strobe accepted only in REPOSO; listo is a
  // one-cycle pulse marking a freshly written func_salida. No backpressure.
  logic [2:0]             estado;
  logic [ancho-1:0]       yb, ym, ya, gb, gm, ga;
  logic signed [AW-1:0]   acumulador;

  logic signed [ancho-1:0] op_y, op_g;
  logic signed [PW-1:0]    producto, producto_aj, desplazado;
  logic signed [AW-1:0]    termino;
  logic [ancho-1:0]        sat_y;
  logic                    sat_c;

  always_comb begin
    op_y = yb;
    op_g = gb;
    case (estado)
      MUL_M: begin op_y = ym; op_g = gm; end
      MUL_A: begin op_y = ya; op_g = ga; end
      default: begin op_y = yb; op_g = gb; end
    endcase
  end

  assign producto = PW'(op_y) * PW'(op_g);

`ifdef MEZCLADOR_REDONDEO_EN
  localparam logic signed [PW-1:0] MEDIO =
    {{(PW-fraccion){1'b0}}, 1'b1, {(fraccion-1){1'b0}}};
  assign producto_aj = producto + MEDIO;
`else
  assign producto_aj = producto;
`endif

  assign desplazado = producto_aj >>> fraccion;
  assign termino    = AW'(desplazado);

  saturador_q #(
    .ancho      (ancho),
    .ancho_acum (AW)
  ) u_saturador (
    .dato    (acumulador),
    .sat     (sat_y),
    .recorte (sat_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      estado      <= REPOSO;
      acumulador  <= '0;
      func_salida <= '0;
      listo       <= 1'b0;
      saturado    <= 1'b0;
      perdido     <= 1'b0;
      yb <= '0; ym <= '0; ya <= '0;
      gb <= '0; gm <= '0; ga <= '0;
    end else begin
      listo <= 1'b0;
      if (en && (estado != REPOSO)) perdido <= 1'b1;
      case (estado)
        REPOSO: begin
          if (en) begin
            yb <= ykbajos;    ym <= ykmedios;   ya <= ykaltos;
            gb <= ganancia_b; gm <= ganancia_m; ga <= ganancia_a;
            estado <= MUL_B;
          end
        end
        MUL_B: begin
          acumulador <= termino;
          estado     <= MUL_M;
        end
        MUL_M: begin
          acumulador <= acumulador + termino;
          estado     <= MUL_A;
        end
        MUL_A: begin
          acumulador <= acumulador + termino;
          estado     <= SATURA;
        end
        SATURA: begin
          func_salida <= sat_y;
          saturado    <= sat_c;
          listo       <= 1'b1;
          estado      <= REPOSO;
        end
        default: estado <= REPOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_mezclador_bandas.sv
// Directed bench for mezclador_bandas; expected values are hand-computed Q8.16.
module tb_mezclador_bandas;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [24:0] ykbajos = '0, ykmedios = '0, ykaltos = '0;
  logic [24:0] ganancia_b = '0, ganancia_m = '0, ganancia_a = '0;
  logic [24:0] func_salida;
  logic        listo, saturado, perdido;

  int checks = 0;
  int failures = 0;

  localparam logic [24:0] Q1 = 25'h0010000;

  mezclador_bandas dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .ykbajos     (ykbajos),
    .ykmedios    (ykmedios),
    .ykaltos     (ykaltos),
    .ganancia_b  (ganancia_b),
    .ganancia_m  (ganancia_m),
    .ganancia_a  (ganancia_a),
    .func_salida (func_salida),
    .listo       (listo),
    .saturado    (saturado),
    .perdido     (perdido)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drivers and samplers all act on the falling edge.
  task automatic aplicar_reset();
    reset = 1'b1;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulso_en(input logic [24:0] b, m, a, g_b, g_m, g_a);
    ykbajos = b; ykmedios = m; ykaltos = a;
    ganancia_b = g_b; ganancia_m = g_m; ganancia_a = g_a;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    ykbajos    = 25'($urandom); ykmedios   = 25'($urandom); ykaltos    = 25'($urandom);
    ganancia_b = 25'($urandom); ganancia_m = 25'($urandom); ganancia_a = 25'($urandom);
  endtask

  task automatic esperar_listo(output int lat);
    lat = 99;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (listo) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (func_salida !== 25'h0) begin failures++; $display("FAIL reset_salida got=%h exp=%h", func_salida, 25'h0); end
    checks++; if (listo !== 1'b0) begin failures++; $display("FAIL reset_listo got=%b exp=0", listo); end
    checks++; if (saturado !== 1'b0) begin failures++; $display("FAIL reset_saturado got=%b exp=0", saturado); end
    checks++; if (perdido !== 1'b0) begin failures++; $display("FAIL reset_perdido got=%b exp=0", perdido); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unidad();
    int lat;
    pulso_en(25'h0004000, 25'h0008000, 25'h0002000, Q1, Q1, Q1);
    esperar_listo(lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL unidad_latencia got=%0d exp=4", lat); end
    checks++; if (func_salida !== 25'h000E000) begin failures++; $display("FAIL unidad_salida got=%h exp=%h", func_salida, 25'h000E000); end
    checks++; if (saturado !== 1'b0) begin failures++; $display("FAIL unidad_saturado got=%b exp=0", saturado); end
    @(negedge clk);
    checks++; if (listo !== 1'b0) begin failures++; $display("FAIL unidad_listo_pulso got=%b exp=0", listo); end
    checks++; if (func_salida !== 25'h000E000) begin failures++; $display("FAIL unidad_retencion got=%h exp=%h", func_salida, 25'h000E000); end
  endtask

  task automatic test_ganancia_simple();
    int lat;
    pulso_en(25'h0018000, 25'h0123456, 25'h0654321, 25'h0020000, 25'h0, 25'h0);
    esperar_listo(lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL simple_latencia got=%0d exp=4", lat); end
    checks++; if (func_salida !== 25'h0030000) begin failures++; $display("FAIL simple_salida got=%h exp=%h", func_salida, 25'h0030000); end
    checks++; if (saturado !== 1'b0) begin failures++; $display("FAIL simple_saturado got=%b exp=0", saturado); end
  endtask

  task automatic test_saturacion();
    int lat;
    pulso_en(25'h0640000, 25'h0640000, 25'h0640000, Q1, Q1, Q1);
    esperar_listo(lat);
    checks++; if (func_salida !== 25'h0FFFFFF) begin failures++; $display("FAIL sat_pos_salida got=%h exp=%h", func_salida, 25'h0FFFFFF); end
    checks++; if (saturado !== 1'b1) begin failures++; $display("FAIL sat_pos_flag got=%b exp=1", saturado); end
    pulso_en(25'h19C0000, 25'h19C0000, 25'h19C0000, Q1, Q1, Q1);
    esperar_listo(lat);
    checks++; if (func_salida !== 25'h1000000) begin failures++; $display("FAIL sat_neg_salida got=%h exp=%h", func_salida, 25'h1000000); end
    checks++; if (saturado !== 1'b1) begin failures++; $display("FAIL sat_neg_flag got=%b exp=1", saturado); end
  endtask

  task automatic test_limites();
    logic [24:0] vb [5] = '{25'h0FFFFFF, 25'h0FFFFFF, 25'h1000000, 25'h1000000, 25'h1FF0000};
    logic [24:0] vm [5] = '{25'h0,       25'h0000001, 25'h0,       25'h1FFFFFF, 25'h0020000};
    logic [24:0] vg [5] = '{Q1,          Q1,          Q1,          Q1,          25'h0008000};
    logic [24:0] vgm[5] = '{25'h0,       Q1,          25'h0,       Q1,          Q1};
    logic [24:0] vy [5] = '{25'h0FFFFFF, 25'h0FFFFFF, 25'h1000000, 25'h1000000, 25'h0018000};
    logic        vs [5] = '{1'b0,        1'b1,        1'b0,        1'b1,        1'b0};
    int lat;
    for (int i = 0; i < 5; i++) begin
      pulso_en(vb[i], vm[i], 25'h0ABCDEF, vg[i], vgm[i], 25'h0);
      esperar_listo(lat);
      checks++; if (func_salida !== vy[i]) begin failures++; $display("FAIL limite%0d_salida got=%h exp=%h", i, func_salida, vy[i]); end
      checks++; if (saturado !== vs[i]) begin failures++; $display("FAIL limite%0d_saturado got=%b exp=%b", i, saturado, vs[i]); end
    end
  endtask

  task automatic test_redondeo();
    int lat;
    logic [24:0] exp_pos, exp_neg;
`ifdef MEZCLADOR_REDONDEO_EN
    exp_pos = 25'h0000001;
    exp_neg = 25'h0000000;
`else
    exp_pos = 25'h0000000;
    exp_neg = 25'h1FFFFFF;
`endif
    pulso_en(25'h0000001, 25'h0000000, 25'h0000000, 25'h0008000, 25'h0, 25'h0);
    esperar_listo(lat);
    checks++; if (func_salida !== exp_pos) begin failures++; $display("FAIL redondeo_pos got=%h exp=%h", func_salida, exp_pos); end
    pulso_en(25'h1FFFFFF, 25'h0000000, 25'h0000000, 25'h0008000, 25'h0, 25'h0);
    esperar_listo(lat);
    checks++; if (func_salida !== exp_neg) begin failures++; $display("FAIL redondeo_neg got=%h exp=%h", func_salida, exp_neg); end
  endtask

  task automatic test_back_to_back();
    int lat;
    aplicar_reset();
    pulso_en(25'h0004000, 25'h0008000, 25'h0002000, Q1, Q1, Q1);
    esperar_listo(lat);
    checks++; if (func_salida !== 25'h000E000) begin failures++; $display("FAIL b2b_primero got=%h exp=%h", func_salida, 25'h000E000); end
    pulso_en(25'h0018000, 25'h0, 25'h0, 25'h0020000, 25'h0, 25'h0);
    esperar_listo(lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL b2b_latencia got=%0d exp=4", lat); end
    checks++; if (func_salida !== 25'h0030000) begin failures++; $display("FAIL b2b_segundo got=%h exp=%h", func_salida, 25'h0030000); end
    checks++; if (perdido !== 1'b0) begin failures++; $display("FAIL b2b_perdido got=%b exp=0", perdido); end
  endtask

  task automatic test_perdido();
    int pulsos;
    int lat;
    logic [24:0] valor;
    aplicar_reset();
    ykbajos = 25'h0004000; ykmedios = 25'h0008000; ykaltos = 25'h0002000;
    ganancia_b = Q1; ganancia_m = Q1; ganancia_a = Q1;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    ykbajos = 25'h0640000; ykmedios = 25'h0640000; ykaltos = 25'h0640000;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    pulsos = 0;
    valor  = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (listo) begin pulsos++; valor = func_salida; end
    end
    checks++; if (pulsos !== 1) begin failures++; $display("FAIL perdido_pulsos got=%0d exp=1", pulsos); end
    checks++; if (valor !== 25'h000E000) begin failures++; $display("FAIL perdido_valor got=%h exp=%h", valor, 25'h000E000); end
    checks++; if (perdido !== 1'b1) begin failures++; $display("FAIL perdido_flag got=%b exp=1", perdido); end
    pulso_en(25'h0018000, 25'h0, 25'h0, 25'h0020000, 25'h0, 25'h0);
    esperar_listo(lat);
    checks++; if (perdido !== 1'b1) begin failures++; $display("FAIL perdido_pegajoso got=%b exp=1", perdido); end
    aplicar_reset();
    checks++; if (perdido !== 1'b0) begin failures++; $display("FAIL perdido_borrado got=%b exp=0", perdido); end
  endtask

  task automatic test_reset_medio();
    int pulsos;
    int lat;
    pulso_en(25'h0018000, 25'h0, 25'h0, 25'h0020000, 25'h0, 25'h0);
    esperar_listo(lat);
    ykbajos = 25'h0004000; ykmedios = 25'h0008000; ykaltos = 25'h0002000;
    ganancia_b = Q1; ganancia_m = Q1; ganancia_a = Q1;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (func_salida !== 25'h0) begin failures++; $display("FAIL rmedio_salida got=%h exp=%h", func_salida, 25'h0); end
    checks++; if (perdido !== 1'b0) begin failures++; $display("FAIL rmedio_perdido got=%b exp=0", perdido); end
    pulsos = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (listo) pulsos++;
    end
    checks++; if (pulsos !== 0) begin failures++; $display("FAIL rmedio_sin_listo got=%0d exp=0", pulsos); end
    en = 1'b1; reset = 1'b1;
    @(negedge clk);
    en = 1'b0; reset = 1'b0;
    pulsos = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (listo) pulsos++;
    end
    checks++; if (pulsos !== 0) begin failures++; $display("FAIL en_y_reset got=%0d exp=0", pulsos); end
    pulso_en(25'h0004000, 25'h0008000, 25'h0002000, Q1, Q1, Q1);
    esperar_listo(lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL rmedio_latencia got=%0d exp=4", lat); end
    checks++; if (func_salida !== 25'h000E000) begin failures++; $display("FAIL rmedio_salida_nueva got=%h exp=%h", func_salida, 25'h000E000); end
  endtask

  initial begin
    test_reset();
    test_unidad();
    test_ganancia_simple();
    test_saturacion();
    test_limites();
    test_redondeo();
    test_back_to_back();
    test_perdido();
    test_reset_medio();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
